leaf_candidate_scanner: RTL and testbench

//  Downstream of the KD-tree internal-node traversal stage. Takes each (leaf_index, query patch) pair the tree

---
 rtl/kd_pkg.sv | 28 ++
 rtl/query_fifo.sv | 63 ++++++
 rtl/leaf_candidate_scanner.sv | 181 ++++++++++++++++++
 tb/tb_leaf_candidate_scanner.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kd_pkg.sv
// Shared KD-tree matcher definitions: geometry, scan FSM states and the query payload.
package kd_pkg;

  localparam int unsigned PATCH_WIDTH   = 55;
  localparam int unsigned COMP_WIDTH    = 11;
  localparam int unsigned ADDRESS_WIDTH = 8;
  localparam int unsigned LEAF_SIZE     = 8;
  localparam int unsigned FIFO_DEPTH    = 4;

  localparam int unsigned NUM_COMP   = PATCH_WIDTH / COMP_WIDTH;
  localparam int unsigned SLOT_W     = $clog2(LEAF_SIZE);
  localparam int unsigned DIST_WIDTH = COMP_WIDTH + $clog2(NUM_COMP);
  localparam int unsigned MEM_AW     = ADDRESS_WIDTH + SLOT_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scan_state_t;

  // One tree output: selected leaf plus the query patch travelling with it.
  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] leaf;
    logic [PATCH_WIDTH-1:0]   patch;
  } query_t;

endpackage

// File: rtl/query_fifo.sv
// Synchronous query FIFO. Occupancy lives in a registered count; full/empty decode from it.
// A push while full is accepted only if a pop happens in the same cycle.
// Ports: clk, rst_n (sync, active-low), push_i/wdata_i, pop_i, head_o (oldest entry), full_o, empty_o.
module query_fifo
  import kd_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push_i,
  input  query_t wdata_i,
  input  logic   pop_i,
  output query_t head_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  query_t          mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // When full, the write slot equals the head slot, so a simultaneous pop frees it.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  // Occupancy next-state
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array, not reset
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers and count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/leaf_candidate_scanner.sv
// Scans every candidate of a KD-tree leaf and reports the one with the smallest L1 distance
// to the query. Queries are buffered in a FIFO because the tree cannot be stalled.
// Ports: clk, rst_n (sync, active-low); in_valid/in_leaf_index/in_patch from the tree;
//        mem_ren/mem_addr/mem_rdata to leaf SRAM (1-cycle read); out_valid/out_ready/out_addr/out_dist
//        result handshake; overflow (sticky query drop); busy (scan active or queries pending).
module leaf_candidate_scanner
  import kd_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [ADDRESS_WIDTH-1:0] in_leaf_index,
  input  logic [PATCH_WIDTH-1:0]   in_patch,
  output logic                     mem_ren,
  output logic [MEM_AW-1:0]        mem_addr,
  input  logic [PATCH_WIDTH-1:0]   mem_rdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [MEM_AW-1:0]        out_addr,
  output logic [DIST_WIDTH-1:0]    out_dist,
  output logic                     overflow,
  output logic                     busy
);

  scan_state_t              state_q, state_d;
  logic [SLOT_W-1:0]        slot_q, slot_d;
  logic [1:0]               drain_cnt_q, drain_cnt_d;
  logic [ADDRESS_WIDTH-1:0] qleaf_q, qleaf_d;
  logic [PATCH_WIDTH-1:0]   qpatch_q, qpatch_d;
  logic                     mem_ren_q, mem_ren_d;
  logic [MEM_AW-1:0]        mem_addr_q, mem_addr_d;
  logic                     out_valid_q, out_valid_d;
  logic [DIST_WIDTH-1:0]    best_dist_q, best_dist_d;
  logic [MEM_AW-1:0]        best_addr_q, best_addr_d;
  logic                     overflow_q;

  logic                     rd_vld_q, p1_vld_q;
  logic [SLOT_W-1:0]        rd_slot_q, p1_slot_q;
  logic [DIST_WIDTH-1:0]    p1_dist_q, l1_c;
  logic [COMP_WIDTH-1:0]    qc, cc, ad;

  query_t                   push_data, head;
  logic                     fifo_full, fifo_empty, pop_c;

  assign push_data = '{leaf: in_leaf_index, patch: in_patch};

  query_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (in_valid),
    .wdata_i (push_data),
    .pop_i   (pop_c),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign mem_ren   = mem_ren_q;
  assign mem_addr  = mem_addr_q;
  assign out_valid = out_valid_q;
  assign out_addr  = best_addr_q;
  assign out_dist  = best_dist_q;
  assign overflow  = overflow_q;
  assign busy      = (state_q != IDLE) || !fifo_empty;

  // L1 distance of the candidate returned by the SRAM this cycle
  always_comb begin
    l1_c = '0;
    qc   = '0;
    cc   = '0;
    ad   = '0;
    for (int unsigned k = 0; k < NUM_COMP; k++) begin
      qc   = qpatch_q[k*COMP_WIDTH +: COMP_WIDTH];
      cc   = mem_rdata[k*COMP_WIDTH +: COMP_WIDTH];
      ad   = (qc > cc) ? (qc - cc) : (cc - qc);
      l1_c = l1_c + DIST_WIDTH'(ad);
    end
  end

  // Scan FSM, read issue and best-candidate tracking
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    drain_cnt_d = drain_cnt_q;
    qleaf_d     = qleaf_q;
    qpatch_d    = qpatch_q;
    mem_ren_d   = 1'b0;
    mem_addr_d  = '0;
    out_valid_d = 1'b0;
    pop_c       = 1'b0;
    best_dist_d = best_dist_q;
    best_addr_d = best_addr_q;

    // Strict compare keeps the lowest slot on ties
    if (p1_vld_q && (p1_dist_q < best_dist_q)) begin
      best_dist_d = p1_dist_q;
      best_addr_d = {qleaf_q, p1_slot_q};
    end

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop_c       = 1'b1;
          qleaf_d     = head.leaf;
          qpatch_d    = head.patch;
          best_dist_d = '1;
          best_addr_d = '0;
          slot_d      = '0;
          state_d     = READ;
        end
      end
      READ: begin
        slot_d = slot_q + SLOT_W'(1);
        if (slot_q == SLOT_W'(LEAF_SIZE - 1)) begin
          state_d     = DRAIN;
          drain_cnt_d = 2'd0;
        end
      end
      DRAIN: begin
        drain_cnt_d = drain_cnt_q + 2'd1;
        if (drain_cnt_q == 2'd2) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Registered read port and result flag follow the next state
    mem_ren_d   = (state_d == READ);
    out_valid_d = (state_d == DONE);
    if (mem_ren_d) mem_addr_d = {qleaf_d, slot_d};
  end

  // State, query and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      drain_cnt_q <= '0;
      qleaf_q     <= '0;
      qpatch_q    <= '0;
      mem_ren_q   <= 1'b0;
      mem_addr_q  <= '0;
      out_valid_q <= 1'b0;
      best_dist_q <= '0;
      best_addr_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      drain_cnt_q <= drain_cnt_d;
      qleaf_q     <= qleaf_d;
      qpatch_q    <= qpatch_d;
      mem_ren_q   <= mem_ren_d;
      mem_addr_q  <= mem_addr_d;
      out_valid_q <= out_valid_d;
      best_dist_q <= best_dist_d;
      best_addr_q <= best_addr_d;
      if (in_valid && fifo_full && !pop_c) overflow_q <= 1'b1;
    end
  end

  // Read pipeline: SRAM data stage, then registered distance with its slot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_vld_q  <= 1'b0;
      rd_slot_q <= '0;
      p1_vld_q  <= 1'b0;
      p1_slot_q <= '0;
      p1_dist_q <= '0;
    end else begin
      rd_vld_q  <= mem_ren_q;
      rd_slot_q <= mem_addr_q[SLOT_W-1:0];
      p1_vld_q  <= rd_vld_q;
      p1_slot_q <= rd_slot_q;
      p1_dist_q <= l1_c;
    end
  end

endmodule

// File: tb/tb_leaf_candidate_scanner.sv
// Self-checking bench for leaf_candidate_scanner: SRAM model, reference best-match model,
// directed scenarios and a randomized query stream.
module tb_leaf_candidate_scanner;
  import kd_pkg::*;

  localparam int unsigned SRAM_WORDS = 1 << MEM_AW;

  logic                     clk;
  logic                     rst_n;
  logic                     in_valid;
  logic [ADDRESS_WIDTH-1:0] in_leaf_index;
  logic [PATCH_WIDTH-1:0]   in_patch;
  logic                     mem_ren;
  logic [MEM_AW-1:0]        mem_addr;
  logic [PATCH_WIDTH-1:0]   mem_rdata;
  logic                     out_valid;
  logic                     out_ready;
  logic [MEM_AW-1:0]        out_addr;
  logic [DIST_WIDTH-1:0]    out_dist;
  logic                     overflow;
  logic                     busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [PATCH_WIDTH-1:0] sram [SRAM_WORDS];
  logic [MEM_AW-1:0]      rd_addr_q [$];
  int                     rd_cyc_q  [$];
  logic [MEM_AW-1:0]      res_addr  [$];
  logic [DIST_WIDTH-1:0]  res_dist  [$];
  int                     exp_addr  [$];
  int                     exp_dist  [$];

  leaf_candidate_scanner dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_leaf_index (in_leaf_index),
    .in_patch      (in_patch),
    .mem_ren       (mem_ren),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_addr      (out_addr),
    .out_dist      (out_dist),
    .overflow      (overflow),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Leaf SRAM: data valid the cycle after the read enable
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= sram[mem_addr];
  end

  // Monitor away from the active edge: reads issued and results accepted
  always @(negedge clk) begin
    if (mem_ren) begin
      rd_addr_q.push_back(mem_addr);
      rd_cyc_q.push_back(cyc);
    end
    if (out_valid && out_ready) begin
      res_addr.push_back(out_addr);
      res_dist.push_back(out_dist);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int l1(input logic [PATCH_WIDTH-1:0] a, input logic [PATCH_WIDTH-1:0] b);
    int s, x, y;
    s = 0;
    for (int k = 0; k < int'(NUM_COMP); k++) begin
      x = int'(a[k*COMP_WIDTH +: COMP_WIDTH]);
      y = int'(b[k*COMP_WIDTH +: COMP_WIDTH]);
      s += (x > y) ? (x - y) : (y - x);
    end
    return s;
  endfunction

  // Reference: smallest L1 over the leaf's candidates, first slot wins ties
  task automatic ref_best(input int leaf, input logic [PATCH_WIDTH-1:0] q, output int baddr, output int bdist);
    int d;
    bdist = -1;
    baddr = 0;
    for (int s = 0; s < int'(LEAF_SIZE); s++) begin
      d = l1(q, sram[leaf * int'(LEAF_SIZE) + s]);
      if (bdist < 0 || d < bdist) begin
        bdist = d;
        baddr = leaf * int'(LEAF_SIZE) + s;
      end
    end
  endtask

  function automatic logic [PATCH_WIDTH-1:0] fill(input int c);
    logic [PATCH_WIDTH-1:0] p;
    p = '0;
    for (int k = 0; k < int'(NUM_COMP); k++) p[k*COMP_WIDTH +: COMP_WIDTH] = COMP_WIDTH'(c);
    return p;
  endfunction

  function automatic logic [PATCH_WIDTH-1:0] rand_patch();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[PATCH_WIDTH-1:0];
  endfunction

  task automatic clear_logs();
    rd_addr_q.delete();
    rd_cyc_q.delete();
    res_addr.delete();
    res_dist.delete();
    exp_addr.delete();
    exp_dist.delete();
  endtask

  task automatic send(input int leaf, input logic [PATCH_WIDTH-1:0] q, input bit expect_it);
    int a, d;
    if (expect_it) begin
      ref_best(leaf, q, a, d);
      exp_addr.push_back(a);
      exp_dist.push_back(d);
    end
    in_valid      = 1'b1;
    in_leaf_index = ADDRESS_WIDTH'(leaf);
    in_patch      = q;
    tick();
    in_valid      = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (mem_ren !== 1'b0)   begin errors++; $display("FAIL reset_mem_ren got %0b want 0", mem_ren); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (out_addr !== '0)    begin errors++; $display("FAIL reset_out_addr got %0d want 0", out_addr); end
    checks++; if (out_dist !== '0)    begin errors++; $display("FAIL reset_out_dist got %0d want 0", out_dist); end
    checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL reset_overflow got %0b want 0", overflow); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int p, vcyc;
    bit got;
    for (int s = 0; s < int'(LEAF_SIZE); s++) sram[5*LEAF_SIZE + s] = (s == 3) ? fill(101) : fill(0);
    clear_logs();
    out_ready = 1'b1;
    p = cyc;
    send(5, fill(100), 1'b1);
    got = 1'b0; vcyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin got = 1'b1; vcyc = cyc; break; end
    end
    checks++; if (!got || vcyc != p + 13) begin errors++; $display("FAIL single_latency got cycle %0d want %0d", vcyc, p + 13); end
    repeat (3) tick();
    checks++; if (rd_addr_q.size() != 8 || rd_cyc_q[0] != p + 2) begin
      errors++; $display("FAIL single_reads got %0d reads first at %0d want 8 at %0d", rd_addr_q.size(), rd_cyc_q.size() ? rd_cyc_q[0] : -1, p + 2);
    end
    for (int i = 0; i < 8 && i < rd_addr_q.size(); i++) begin
      checks++; if (rd_addr_q[i] !== MEM_AW'(40 + i)) begin errors++; $display("FAIL single_addr%0d got %0d want %0d", i, rd_addr_q[i], 40 + i); end
    end
    checks++; if (res_addr.size() != 1 || res_addr[0] !== MEM_AW'(43) || res_dist[0] !== DIST_WIDTH'(5)) begin
      errors++; $display("FAIL single_result got %0d results addr %0d dist %0d want addr 43 dist 5", res_addr.size(),
                         res_addr.size() ? res_addr[0] : 0, res_dist.size() ? res_dist[0] : 0);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got %0b want 0", busy); end
  endtask

  task automatic test_tie();
    int leaf;
    logic [PATCH_WIDTH-1:0] q, c;
    leaf = int'($urandom_range(0, 255));
    q = '0;
    for (int k = 0; k < int'(NUM_COMP); k++) q[k*COMP_WIDTH +: COMP_WIDTH] = COMP_WIDTH'($urandom_range(20, 2000));
    for (int s = 0; s < int'(LEAF_SIZE); s++) begin
      if (s == 2) begin
        c = q; c[0 +: COMP_WIDTH] = c[0 +: COMP_WIDTH] + COMP_WIDTH'(7);
      end else if (s == 6) begin
        c = q;
        c[COMP_WIDTH +: COMP_WIDTH]   = c[COMP_WIDTH +: COMP_WIDTH] - COMP_WIDTH'(3);
        c[3*COMP_WIDTH +: COMP_WIDTH] = c[3*COMP_WIDTH +: COMP_WIDTH] + COMP_WIDTH'(4);
      end else begin
        c = rand_patch();
        while (l1(q, c) <= 7) c = rand_patch();
      end
      sram[leaf*LEAF_SIZE + s] = c;
    end
    clear_logs();
    out_ready = 1'b1;
    send(leaf, q, 1'b1);
    for (int i = 0; i < 60 && res_addr.size() < 1; i++) tick();
    checks++; if (res_addr.size() != 1) begin errors++; $display("FAIL tie_count got %0d want 1", res_addr.size()); end
    else begin
      checks++; if (res_addr[0] !== MEM_AW'(leaf*8 + 2) || res_dist[0] !== DIST_WIDTH'(7)) begin
        errors++; $display("FAIL tie_result got addr %0d dist %0d want addr %0d dist 7", res_addr[0], res_dist[0], leaf*8 + 2);
      end
    end
  endtask

  task automatic test_random();
    int sent, gap;
    bit done;
    for (int i = 0; i < int'(SRAM_WORDS); i++) sram[i] = rand_patch();
    clear_logs();
    sent = 0; gap = 0; done = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (sent < 12 && gap == 0 && (sent - res_addr.size()) < 3) begin
        send(int'($urandom_range(0, 255)), rand_patch(), 1'b1);
        sent++;
        gap = int'($urandom_range(0, 15));
      end else begin
        if (gap > 0) gap--;
        tick();
      end
      if (sent == 12 && res_addr.size() == 12) begin done = 1'b1; break; end
    end
    out_ready = 1'b1;
    checks++; if (!done) begin errors++; $display("FAIL random_timeout got %0d results want 12", res_addr.size()); end
    for (int i = 0; i < 12 && i < res_addr.size(); i++) begin
      checks++; if (res_addr[i] !== MEM_AW'(exp_addr[i]) || res_dist[i] !== DIST_WIDTH'(exp_dist[i])) begin
        errors++; $display("FAIL random_result%0d got addr %0d dist %0d want addr %0d dist %0d", i, res_addr[i], res_dist[i], exp_addr[i], exp_dist[i]);
      end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL random_overflow got %0b want 0", overflow); end
  endtask

  task automatic test_extremes();
    int leaf;
    leaf = int'($urandom_range(0, 255));
    for (int s = 0; s < int'(LEAF_SIZE); s++) sram[leaf*LEAF_SIZE + s] = fill(2047);
    clear_logs();
    out_ready = 1'b1;
    send(leaf, fill(0), 1'b1);
    for (int i = 0; i < 60 && res_addr.size() < 1; i++) tick();
    for (int s = 0; s < int'(LEAF_SIZE); s++) sram[leaf*LEAF_SIZE + s] = fill(0);
    send(leaf, fill(2047), 1'b1);
    for (int i = 0; i < 60 && res_addr.size() < 2; i++) tick();
    checks++; if (res_addr.size() != 2) begin errors++; $display("FAIL extreme_count got %0d want 2", res_addr.size()); end
    for (int i = 0; i < 2 && i < res_addr.size(); i++) begin
      checks++; if (res_addr[i] !== MEM_AW'(leaf*8) || res_dist[i] !== DIST_WIDTH'(10235)) begin
        errors++; $display("FAIL extreme_result%0d got addr %0d dist %0d want addr %0d dist 10235", i, res_addr[i], res_dist[i], leaf*8);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [MEM_AW-1:0]     hold_addr;
    logic [DIST_WIDTH-1:0] hold_dist;
    int bad, h;
    bit got;
    for (int i = 0; i < int'(SRAM_WORDS); i++) sram[i] = rand_patch();
    clear_logs();
    out_ready = 1'b0;
    send(int'($urandom_range(0, 255)), rand_patch(), 1'b1);
    send(int'($urandom_range(0, 255)), rand_patch(), 1'b1);
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin got = 1'b1; break; end
    end
    checks++; if (!got) begin errors++; $display("FAIL bp_valid_timeout got 0 want 1"); end
    hold_addr = out_addr; hold_dist = out_dist;
    checks++; if (hold_addr !== MEM_AW'(exp_addr[0]) || hold_dist !== DIST_WIDTH'(exp_dist[0])) begin
      errors++; $display("FAIL bp_first got addr %0d dist %0d want addr %0d dist %0d", hold_addr, hold_dist, exp_addr[0], exp_dist[0]);
    end
    rd_addr_q.delete(); rd_cyc_q.delete();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_addr !== hold_addr || out_dist !== hold_dist || mem_ren !== 1'b0 || busy !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold got %0d unstable cycles want 0", bad); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    h = cyc;
    @(negedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %0b want 0", out_valid); end
    for (int i = 0; i < 60 && res_addr.size() < 2; i++) tick();
    checks++; if (rd_cyc_q.size() == 0 || rd_cyc_q[0] != h + 2) begin
      errors++; $display("FAIL bp_restart got first read cycle %0d want %0d", rd_cyc_q.size() ? rd_cyc_q[0] : -1, h + 2);
    end
    checks++; if (res_addr.size() != 2 || res_addr[1] !== MEM_AW'(exp_addr[1]) || res_dist[1] !== DIST_WIDTH'(exp_dist[1])) begin
      errors++; $display("FAIL bp_second got %0d results want 2 with addr %0d dist %0d", res_addr.size(), exp_addr[1], exp_dist[1]);
    end
  endtask

  task automatic test_burst();
    bit got;
    clear_logs();
    out_ready = 1'b1;
    send(int'($urandom_range(0, 255)), rand_patch(), 1'b1);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd_addr_q.size() > 0) begin got = 1'b1; break; end
    end
    tick();
    checks++; if (!got || overflow !== 1'b0) begin errors++; $display("FAIL burst_pre got started %0b overflow %0b want 1 0", got, overflow); end
    for (int i = 0; i < 5; i++) send(int'($urandom_range(0, 255)), rand_patch(), i < 4);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL burst_overflow got %0b want 1", overflow); end
    for (int i = 0; i < 200 && res_addr.size() < 5; i++) tick();
    repeat (30) tick();
    checks++; if (res_addr.size() != 5) begin errors++; $display("FAIL burst_count got %0d want 5", res_addr.size()); end
    for (int i = 0; i < 5 && i < res_addr.size(); i++) begin
      checks++; if (res_addr[i] !== MEM_AW'(exp_addr[i]) || res_dist[i] !== DIST_WIDTH'(exp_dist[i])) begin
        errors++; $display("FAIL burst_result%0d got addr %0d dist %0d want addr %0d dist %0d", i, res_addr[i], res_dist[i], exp_addr[i], exp_dist[i]);
      end
    end
    checks++; if (overflow !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL burst_sticky got overflow %0b busy %0b want 1 0", overflow, busy); end
  endtask

  task automatic test_reset_mid_scan();
    int p;
    clear_logs();
    out_ready = 1'b1;
    p = cyc;
    for (int i = 0; i < 3; i++) send(int'($urandom_range(0, 255)), rand_patch(), 1'b0);
    while (cyc < p + 4) tick();
    rst_n = 1'b0;
    tick();
    checks++; if (mem_ren !== 1'b0 || out_valid !== 1'b0 || out_addr !== '0 || out_dist !== '0 || overflow !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs got ren %0b valid %0b addr %0d dist %0d ovf %0b busy %0b want all 0",
                         mem_ren, out_valid, out_addr, out_dist, overflow, busy);
    end
    rst_n = 1'b1;
    clear_logs();
    repeat (40) tick();
    checks++; if (res_addr.size() != 0 || rd_addr_q.size() != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL midreset_stale got %0d results %0d reads busy %0b want 0 0 0", res_addr.size(), rd_addr_q.size(), busy);
    end
    send(int'($urandom_range(0, 255)), rand_patch(), 1'b1);
    for (int i = 0; i < 60 && res_addr.size() < 1; i++) tick();
    checks++; if (res_addr.size() != 1 || res_addr[0] !== MEM_AW'(exp_addr[0]) || res_dist[0] !== DIST_WIDTH'(exp_dist[0])) begin
      errors++; $display("FAIL midreset_recover got %0d results want addr %0d dist %0d", res_addr.size(), exp_addr[0], exp_dist[0]);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    in_valid      = 1'b0;
    in_leaf_index = '0;
    in_patch      = '0;
    out_ready     = 1'b1;
    mem_rdata     = '0;
    for (int i = 0; i < int'(SRAM_WORDS); i++) sram[i] = '0;
    test_reset();
    test_single();
    test_tie();
    test_random();
    test_extremes();
    test_backpressure();
    test_burst();
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
